// File: rtl/sdft_sample_window_if.sv
// Signal bundle between the ADC/SDFT-core side and the sample window front end.
// The master modport is the window block: it consumes adc/sdft_ready and drives the rest.
interface sdft_sample_window_if #(
    parameter int unsigned data_width = 8
);
    logic signed [data_width-1:0] adc;
    logic                         sdft_ready;
    logic                         start;
    logic signed [data_width:0]   delta;
    logic signed [data_width-1:0] sample_new;
    logic signed [data_width-1:0] sample_old;
    logic                         window_full;
    logic                         overrun;

    modport master (
        input  adc, sdft_ready,
        output start, delta, sample_new, sample_old, window_full, overrun
    );

    modport slave (
        output adc, sdft_ready,
        input  start, delta, sample_new, sample_old, window_full, overrun
    );
endinterface

// File: rtl/sdft_sample_window.sv
// Sliding-DFT front end: samples adc on a divided tick, keeps the last freq_bins samples
// in a circular single-port RAM and hands x[n], x[n-N] and their difference to the core.
module sdft_sample_window #(
    parameter int unsigned data_width = 8,
    parameter int unsigned freq_bins  = 16,
    parameter int unsigned addr_width = 4,
    parameter int unsigned sample_div = 64
) (
    input logic                  clk,
    input logic                  reset,
    sdft_sample_window_if.master bus
);
    localparam int unsigned div_width = $clog2(sample_div);
    localparam logic [div_width-1:0]  div_last = div_width'(sample_div - 1);
    localparam logic [addr_width-1:0] ptr_last = addr_width'(freq_bins - 1);

    typedef enum logic [2:0] {StClear, StIdle, StRead, StWrite, StIssue} state_e;

    state_e                       state_q, state_d;
    logic [div_width-1:0]         div_q, div_d;
    logic [addr_width-1:0]        clr_ptr_q, clr_ptr_d;
    logic [addr_width-1:0]        wr_ptr_q, wr_ptr_d;
    logic signed [data_width-1:0] sample_new_q, sample_old_q;
    logic signed [data_width:0]   delta_q;
    logic                         start_q, start_d;
    logic                         full_q, overrun_q;

    logic [data_width-1:0] ram [freq_bins];

    logic                  tick;
    logic                  cap_en, rd_en, wr_en, ovr_set;
    logic                  ram_we;
    logic [addr_width-1:0] ram_addr;
    logic [data_width-1:0] ram_wdata;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        start_d   = 1'b0;
        cap_en    = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        ovr_set   = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = wr_ptr_q;
        ram_wdata = sample_new_q;
        tick      = (div_q == div_last);
        div_d     = tick ? '0 : div_q + 1'b1;

        unique case (state_q)
            StClear: begin
                // Divider is parked so the first tick lands a full period after CLEAR.
                div_d     = '0;
                ram_we    = 1'b1;
                ram_addr  = clr_ptr_q;
                ram_wdata = '0;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == ptr_last) state_d = StIdle;
            end
            StIdle: begin
                if (tick) begin
                    cap_en  = 1'b1;
                    state_d = StRead;
                end
            end
            StRead: begin
                rd_en   = 1'b1;
                ovr_set = tick;
                state_d = StWrite;
            end
            StWrite: begin
                wr_en    = 1'b1;
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                ovr_set  = tick;
                state_d  = StIssue;
            end
            StIssue: begin
                ovr_set = tick;
                if (bus.sdft_ready) begin
                    start_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StClear;
            div_q        <= '0;
            clr_ptr_q    <= '0;
            wr_ptr_q     <= '0;
            sample_new_q <= '0;
            sample_old_q <= '0;
            delta_q      <= '0;
            start_q      <= 1'b0;
            full_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            clr_ptr_q <= clr_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            start_q   <= start_d;
            if (cap_en) sample_new_q <= bus.adc;
            if (rd_en) sample_old_q <= ram[ram_addr];
            if (wr_en) begin
                delta_q <= {sample_new_q[data_width-1], sample_new_q}
                         - {sample_old_q[data_width-1], sample_old_q};
            end
            if (wr_en && wr_ptr_q == ptr_last) full_q <= 1'b1;
            if (ovr_set) overrun_q <= 1'b1;
        end
    end

    // Write port kept reset-free so the array maps onto a block RAM.
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
    end

    assign bus.start       = start_q;
    assign bus.delta       = delta_q;
    assign bus.sample_new  = sample_new_q;
    assign bus.sample_old  = sample_old_q;
    assign bus.window_full = full_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_sdft_sample_window.sv
// Bench for sdft_sample_window: randomized and directed sample streams checked against a
// queue-based model of the last N samples.
module tb_sdft_sample_window;
    localparam int DW  = 8;
    localparam int N   = 16;
    localparam int AW  = 4;
    localparam int DIV = 64;
    localparam int LIM = 2 * DIV + 10;
    localparam int FIRST_START = N + DIV + 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sdft_sample_window_if #(.data_width(DW)) bus ();

    sdft_sample_window #(
        .data_width(DW),
        .freq_bins (N),
        .addr_width(AW),
        .sample_div(DIV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad = 0;
    int win[$];
    int fills;

    task automatic model_reset();
        win = {};
        for (int i = 0; i < N; i++) win.push_back(0);
        fills = 0;
    endtask

    task automatic model_push(input int x, output int old, output int dlt, output bit full);
        old = win.pop_front();
        win.push_back(x);
        fills++;
        dlt  = x - old;
        full = (fills >= N);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.sdft_ready = 1'b1;
        bus.adc        = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wait_start(input int limit, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.start === 1'b1) got = 1'b1;
        end
    endtask

    task automatic run_sample(input int x, output bit got, output int cyc);
        bus.adc = DW'(x);
        wait_start(LIM, got, cyc);
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(255, 0)) - 128;
    endfunction

    task automatic test_reset();
        bit got;
        int cyc, old, dlt;
        bit full;
        reset = 1'b1;
        bus.sdft_ready = 1'b1;
        bus.adc = DW'(50);
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.start !== 1'b0) begin bad++; $display("FAIL rst_start: got %b want 0", bus.start); end
        total++; if (bus.delta !== '0) begin bad++; $display("FAIL rst_delta: got %0d want 0", bus.delta); end
        total++; if (bus.sample_new !== '0) begin bad++; $display("FAIL rst_new: got %0d want 0", bus.sample_new); end
        total++; if (bus.sample_old !== '0) begin bad++; $display("FAIL rst_old: got %0d want 0", bus.sample_old); end
        total++; if (bus.window_full !== 1'b0) begin bad++; $display("FAIL rst_full: got %b want 0", bus.window_full); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun: got %b want 0", bus.overrun); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        wait_start(LIM, got, cyc);
        model_push(50, old, dlt, full);
        total++; if (!got) begin bad++; $display("FAIL t1_start: none within %0d cycles, want one", LIM); end
        total++; if (cyc != FIRST_START) begin bad++; $display("FAIL t1_latency: got %0d want %0d", cyc, FIRST_START); end
        total++; if (bus.sample_old !== DW'(old)) begin bad++; $display("FAIL t1_old: got %0d want %0d", bus.sample_old, old); end
        total++; if (bus.delta !== (DW+1)'(dlt)) begin bad++; $display("FAIL t1_delta: got %0d want %0d", bus.delta, dlt); end
        total++; if (bus.sample_new !== DW'(50)) begin bad++; $display("FAIL t1_new: got %0d want 50", bus.sample_new); end
        total++; if (bus.window_full !== full) begin bad++; $display("FAIL t1_full: got %b want %b", bus.window_full, full); end
        @(posedge clk);
        #1;
        total++; if (bus.start !== 1'b0) begin bad++; $display("FAIL t1_pulse: got %b want 0", bus.start); end
        wait_start(20, got, cyc);
        total++; if (got) begin bad++; $display("FAIL t1_extra_start: got 1 want 0"); end
    endtask

    task automatic test_constant();
        bit got, full;
        int cyc, old, dlt;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            run_sample(100, got, cyc);
            model_push(100, old, dlt, full);
            total++; if (!got) begin bad++; $display("FAIL t2_start k=%0d: none, want one", k); end
            total++; if (bus.delta !== (DW+1)'(dlt)) begin bad++; $display("FAIL t2_delta k=%0d: got %0d want %0d", k, bus.delta, dlt); end
            total++; if (bus.window_full !== full) begin bad++; $display("FAIL t2_full k=%0d: got %b want %b", k, bus.window_full, full); end
        end
    endtask

    task automatic test_square();
        bit got, full;
        int cyc, old, dlt, x;
        do_reset();
        for (int k = 0; k < 56; k++) begin
            x = (k < 36) ? (((k / 3) % 2 == 0) ? -100 : 100) : rnd_sample();
            run_sample(x, got, cyc);
            model_push(x, old, dlt, full);
            total++; if (!got) begin bad++; $display("FAIL t3_start k=%0d: none, want one", k); end
            total++; if (bus.delta !== (DW+1)'(dlt)) begin bad++; $display("FAIL t3_delta k=%0d: got %0d want %0d", k, bus.delta, dlt); end
            total++; if (bus.sample_old !== DW'(old)) begin bad++; $display("FAIL t3_old k=%0d: got %0d want %0d", k, bus.sample_old, old); end
            total++; if (bus.sample_new !== DW'(x)) begin bad++; $display("FAIL t3_new k=%0d: got %0d want %0d", k, bus.sample_new, x); end
            total++; if (bus.window_full !== full) begin bad++; $display("FAIL t3_full k=%0d: got %b want %b", k, bus.window_full, full); end
        end
    endtask

    task automatic test_extremes();
        bit got, full;
        int cyc, old, dlt, x;
        do_reset();
        for (int k = 0; k < N + 2; k++) begin
            if (k == 0 || k == N + 1) x = -128;
            else if (k == 1 || k == N) x = 127;
            else x = rnd_sample();
            run_sample(x, got, cyc);
            model_push(x, old, dlt, full);
            total++; if (bus.delta !== (DW+1)'(dlt)) begin bad++; $display("FAIL t4_delta k=%0d: got %0d want %0d", k, bus.delta, dlt); end
        end
        // Last two samples hit the extremes: 127-(-128) then -128-127.
        total++; if (dlt != -255 || bus.delta !== -9'sd255) begin bad++; $display("FAIL t4_neg_extreme: got %0d want -255", bus.delta); end
    endtask

    task automatic test_overrun();
        bit got, full;
        int cyc, old, dlt, a, x;
        do_reset();
        run_sample(rnd_sample(), got, cyc);
        x = 0;
        model_reset();
        model_push(int'(bus.sample_new), old, dlt, full);
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL t5_ovr_pre: got %b want 0", bus.overrun); end
        a = 42;
        bus.adc = DW'(a);
        bus.sdft_ready = 1'b0;
        repeat (70) @(posedge clk);
        bus.adc = DW'(-77);
        got = 1'b0;
        for (int i = 0; i < 130; i++) begin
            @(posedge clk);
            #1;
            if (bus.start === 1'b1) got = 1'b1;
        end
        total++; if (got) begin bad++; $display("FAIL t5_start_blocked: got 1 want 0"); end
        total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL t5_ovr_set: got %b want 1", bus.overrun); end
        bus.sdft_ready = 1'b1;
        wait_start(5, got, cyc);
        model_push(a, old, dlt, full);
        total++; if (!got) begin bad++; $display("FAIL t5_release: no start, want one"); end
        total++; if (bus.delta !== (DW+1)'(dlt)) begin bad++; $display("FAIL t5_delta: got %0d want %0d", bus.delta, dlt); end
        wait_start(40, got, cyc);
        total++; if (got) begin bad++; $display("FAIL t5_double_start: got 1 want 0"); end
        for (int k = 0; k < N; k++) begin
            x = rnd_sample();
            run_sample(x, got, cyc);
            model_push(x, old, dlt, full);
            total++; if (bus.sample_old !== DW'(old)) begin bad++; $display("FAIL t5_old k=%0d: got %0d want %0d", k, bus.sample_old, old); end
            total++; if (bus.delta !== (DW+1)'(dlt)) begin bad++; $display("FAIL t5_delta k=%0d: got %0d want %0d", k, bus.delta, dlt); end
        end
        total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL t5_ovr_sticky: got %b want 1", bus.overrun); end
    endtask

    task automatic test_reset_mid();
        bit got, full;
        int cyc, old, dlt;
        do_reset();
        run_sample(90, got, cyc);
        bus.adc = DW'(33);
        // Next capture is 61 edges after a start; one edge later the block is writing.
        repeat (62) @(posedge clk);
        #2;
        total++; if (bus.sample_new !== DW'(33)) begin bad++; $display("FAIL t6_captured: got %0d want 33", bus.sample_new); end
        reset = 1'b1;
        #1;
        total++; if (bus.sample_new !== '0) begin bad++; $display("FAIL t6_new: got %0d want 0", bus.sample_new); end
        total++; if (bus.sample_old !== '0) begin bad++; $display("FAIL t6_old: got %0d want 0", bus.sample_old); end
        total++; if (bus.delta !== '0) begin bad++; $display("FAIL t6_delta: got %0d want 0", bus.delta); end
        total++; if (bus.start !== 1'b0) begin bad++; $display("FAIL t6_start: got %b want 0", bus.start); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        run_sample(-61, got, cyc);
        model_push(-61, old, dlt, full);
        total++; if (cyc != FIRST_START) begin bad++; $display("FAIL t6_latency: got %0d want %0d", cyc, FIRST_START); end
        total++; if (bus.sample_old !== DW'(old)) begin bad++; $display("FAIL t6_first_old: got %0d want %0d", bus.sample_old, old); end
        total++; if (bus.delta !== (DW+1)'(dlt)) begin bad++; $display("FAIL t6_first_delta: got %0d want %0d", bus.delta, dlt); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.adc = '0;
        bus.sdft_ready = 1'b1;
        test_reset();
        test_constant();
        test_square();
        test_extremes();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
